// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mul_sequencer
//  Purpose  : Shares one 16-bit HACK ALU between the CPU datapath and a
//             shift-add multiply engine. While idle the CPU drives the ALU
//             directly. An accepted multiply request stalls the CPU and steps
//             the ALU through add/double iterations, producing a*b mod 2^WIDTH.
//  Revision : 1.0  initial release
// ============================================================================
module alu_mul_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  // CPU side of the ALU
  input  logic [WIDTH-1:0] cpu_x_i,
  input  logic [WIDTH-1:0] cpu_y_i,
  input  logic [5:0]       cpu_ctl_i,
  output logic             cpu_stall_o,
  // Multiply request
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  // Multiply response
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] resp_data_o,
  output logic             resp_zr_o,
  output logic             resp_ng_o,
  // Shared ALU
  output logic [WIDTH-1:0] alu_x_o,
  output logic [WIDTH-1:0] alu_y_o,
  output logic [5:0]       alu_ctl_o,
  input  logic [WIDTH-1:0] alu_out_i,
  input  logic             alu_zr_i,
  input  logic             alu_ng_i
);

  // ALU control words {zx,nx,zy,ny,f,no}
  localparam logic [5:0] ALU_CTL_ADD   = 6'b000010;  // x + y
  localparam logic [5:0] ALU_CTL_PASSX = 6'b001100;  // x & ~0 = x

  // Last legal iteration index; bounds the loop even if mplier never drains
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DBL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] mplier_shr;
  assign mplier_shr = mplier_q >> 1;

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and register updates; ALU result is captured in ADD/DBL
  always_comb begin
    state_d  = state_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          prod_d   = '0;
          mcand_d  = req_a_i;
          mplier_d = req_b_i;
          cnt_d    = '0;
          if (req_b_i == '0) begin
            state_d = S_DONE;
          end else if (req_b_i[0]) begin
            state_d = S_ADD;
          end else begin
            state_d = S_DBL;
          end
        end
      end
      S_ADD: begin
        prod_d  = alu_out_i;
        state_d = S_DBL;
      end
      S_DBL: begin
        mcand_d  = alu_out_i;
        mplier_d = mplier_shr;
        cnt_d    = cnt_q + CNT_W'(1);
        if ((mplier_shr == '0) || (cnt_q == CNT_LAST)) begin
          state_d = S_DONE;
        end else if (mplier_q[1]) begin
          state_d = S_ADD;
        end else begin
          state_d = S_DBL;
        end
      end
      S_DONE: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ALU operand mux: CPU passthrough when idle, engine operands otherwise
  always_comb begin
    alu_x_o   = cpu_x_i;
    alu_y_o   = cpu_y_i;
    alu_ctl_o = cpu_ctl_i;
    case (state_q)
      S_ADD: begin
        alu_x_o   = prod_q;
        alu_y_o   = mcand_q;
        alu_ctl_o = ALU_CTL_ADD;
      end
      S_DBL: begin
        alu_x_o   = mcand_q;
        alu_y_o   = mcand_q;
        alu_ctl_o = ALU_CTL_ADD;
      end
      S_DONE: begin
        // Pass the product through the ALU so its flags describe the result
        alu_x_o   = prod_q;
        alu_y_o   = '0;
        alu_ctl_o = ALU_CTL_PASSX;
      end
      default: begin
        alu_x_o   = cpu_x_i;
        alu_y_o   = cpu_y_i;
        alu_ctl_o = cpu_ctl_i;
      end
    endcase
  end

  // Handshake and response outputs are decoded purely from state
  always_comb begin
    req_ready_o  = (state_q == S_IDLE);
    cpu_stall_o  = (state_q != S_IDLE);
    resp_valid_o = (state_q == S_DONE);
    resp_data_o  = prod_q;
    resp_zr_o    = alu_zr_i;
    resp_ng_o    = alu_ng_i;
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_mul_sequencer
//  Purpose  : Self-checking bench for alu_mul_sequencer with a behavioural
//             HACK ALU attached and an arithmetic product/latency reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_mul_sequencer;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] cpu_x, cpu_y;
  logic [5:0]       cpu_ctl;
  logic             cpu_stall;
  logic             req_valid, req_ready;
  logic [WIDTH-1:0] req_a, req_b;
  logic             resp_valid, resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             resp_zr, resp_ng;
  logic [WIDTH-1:0] alu_x, alu_y, alu_out;
  logic [5:0]       alu_ctl;
  logic             alu_zr, alu_ng;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_mul_sequencer #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_x_i      (cpu_x),
    .cpu_y_i      (cpu_y),
    .cpu_ctl_i    (cpu_ctl),
    .cpu_stall_o  (cpu_stall),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .resp_zr_o    (resp_zr),
    .resp_ng_o    (resp_ng),
    .alu_x_o      (alu_x),
    .alu_y_o      (alu_y),
    .alu_ctl_o    (alu_ctl),
    .alu_out_i    (alu_out),
    .alu_zr_i     (alu_zr),
    .alu_ng_i     (alu_ng)
  );

  // Behavioural HACK ALU that the sequencer drives
  always_comb begin
    logic [WIDTH-1:0] x1, y1, o1;
    x1 = alu_ctl[5] ? '0 : alu_x;
    x1 = alu_ctl[4] ? ~x1 : x1;
    y1 = alu_ctl[3] ? '0 : alu_y;
    y1 = alu_ctl[2] ? ~y1 : y1;
    o1 = alu_ctl[1] ? (x1 + y1) : (x1 & y1);
    o1 = alu_ctl[0] ? ~o1 : o1;
    alu_out = o1;
    alu_zr  = (o1 == '0);
    alu_ng  = o1[WIDTH-1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: product and number of clock edges from accept to DONE
  function automatic int ref_latency(input logic [WIDTH-1:0] b);
    int pc, hi;
    if (b == 0) return 0;
    pc = 0;
    hi = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (b[i]) begin
        pc++;
        hi = i;
      end
    end
    return pc + hi + 1;
  endfunction

  task automatic do_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int hold);
    logic [31:0]      full;
    logic [WIDTH-1:0] exp_p;
    int               edges;
    logic             stall_bad;
    full  = 32'(a) * 32'(b);
    exp_p = full[WIDTH-1:0];
    @(negedge clk);
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_a      = a;
    req_b      = b;
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
    edges     = 0;
    stall_bad = 1'b0;
    while (!resp_valid && edges < 100) begin
      if (!cpu_stall || req_ready) stall_bad = 1'b1;
      @(negedge clk);
      edges++;
    end
    chk("resp_timeout", 32'(resp_valid), 32'd1);
    chk("stall_during_op", 32'(stall_bad), 32'd0);
    chk("latency", 32'(edges), 32'(ref_latency(b)));
    chk("resp_data", 32'(resp_data), 32'(exp_p));
    chk("resp_zr", 32'(resp_zr), 32'(exp_p == '0));
    chk("resp_ng", 32'(resp_ng), 32'(exp_p[WIDTH-1]));
    chk("stall_in_done", 32'(cpu_stall), 32'd1);
    // Backpressure with stray requests that must be ignored
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_data", 32'(resp_data), 32'(exp_p));
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    // Release while a request is still presented: it must not be taken here
    req_valid  = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    chk("idle_after_resp", 32'(req_ready), 32'd1);
    chk("no_valid_after_resp", 32'(resp_valid), 32'd0);
    chk("no_stall_after_resp", 32'(cpu_stall), 32'd0);
  endtask

  task automatic check_passthrough();
    cpu_x   = 16'($urandom);
    cpu_y   = 16'($urandom);
    cpu_ctl = 6'($urandom);
    #1;
    chk("pass_x", 32'(alu_x), 32'(cpu_x));
    chk("pass_y", 32'(alu_y), 32'(cpu_y));
    chk("pass_ctl", 32'(alu_ctl), 32'(cpu_ctl));
  endtask

  initial begin
    rst_n      = 1'b0;
    cpu_x      = '0;
    cpu_y      = '0;
    cpu_ctl    = '0;
    req_valid  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);

    // Directed passthrough case
    cpu_x   = 16'd7;
    cpu_y   = 16'd5;
    cpu_ctl = 6'b000010;
    #1;
    chk("pass_x_dir", 32'(alu_x), 32'd7);
    chk("pass_y_dir", 32'(alu_y), 32'd5);
    chk("pass_ctl_dir", 32'(alu_ctl), 32'b000010);
    chk("pass_sum_dir", 32'(alu_out), 32'd12);
    for (int i = 0; i < 4; i++) check_passthrough();

    // Directed multiplies
    do_mul(16'd3, 16'd5, 0);
    do_mul(16'h1234, 16'h0000, 0);
    do_mul(16'hFFFF, 16'hFFFF, 0);
    do_mul(16'h0100, 16'h0100, 0);
    do_mul(16'hFFFE, 16'd3, 0);
    do_mul(16'd1, 16'd1, 0);
    do_mul(16'hABCD, 16'h8000, 0);
    do_mul(16'd9, 16'd7, 5);

    // Randomized multiplies with random backpressure
    for (int n = 0; n < 30; n++) begin
      do_mul(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
      check_passthrough();
    end

    // Reset in the middle of a long multiply
    @(negedge clk);
    req_valid = 1'b1;
    req_a     = 16'h5555;
    req_b     = 16'hFFFF;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("midop_busy", 32'(cpu_stall), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_stall", 32'(cpu_stall), 32'd0);
    chk("midrst_valid", 32'(resp_valid), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    check_passthrough();
    repeat (3) @(negedge clk);
    chk("midrst_no_resp", 32'(resp_valid), 32'd0);
    do_mul(16'd1234, 16'd56, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
